alu_seq_param: RTL and testbench
================================

ALU_SEQ_PARAM -- requirements
Module: alu_seq_param

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; legal range 8..64.
REQ-002 Parameter SHW, default 5: shift-amount width; SHALL equal ceil(log2(WIDTH)).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 A, B  input  WIDTH each  operands.
REQ-008 Cin, DinL, DinR  input  1 each  carry-in, left-shift fill bit, right-shift fill bit.
REQ-009 sel  input  4  opcode; shamt  input  SHW  shift distance.
REQ-010 F  output  WIDTH  registered result.
REQ-011 Cout, zero, neg, ovf  output  1 each  registered status flags.
REQ-012 out_valid  output  1  F and flags valid; out_ready  input  1  consumer takes result.

Function
REQ-013 Transfer occurs when in_valid && in_ready; A, B, Cin, DinL, DinR, sel, shamt are captured then, and later input changes SHALL NOT affect that operation.
REQ-014 FSM states IDLE, SHIFT, DONE; in_ready = (IDLE) or (DONE && out_ready); out_valid = 1 only in DONE.
REQ-015 sel[3:2]=00 arithmetic: F = A + Y + Cin (mod 2^WIDTH), Y = 0 / B / ~B / all-ones for sel[1:0] = 00/01/10/11; Cout = bit WIDTH of the WIDTH+1-bit sum.
REQ-016 ovf = (A[MSB]==Y[MSB]) && (F[MSB]!=A[MSB]) for arithmetic; ovf = 0 for all other ops.
REQ-017 sel[3:2]=01 logic: F = A&B, A|B, A^B, ~A for sel[1:0] = 00/01/10/11; Cout = 0.
REQ-018 sel[3:2]=10 shift right by shamt: each step F <= {DinR, F[WIDTH-1:1]}; sel[1:0] ignored.
REQ-019 sel[3:2]=11 shift left by shamt: each step F <= {F[WIDTH-2:0], DinL}; sel[1:0] ignored.
REQ-020 Shifts: Cout = last bit shifted out; shamt=0 gives F=A, Cout=0.
REQ-021 Arithmetic, logic and shamt=0 shifts: IDLE -> DONE, out_valid asserted in the cycle after acceptance (latency 1).
REQ-022 Shifts with shamt>0: IDLE -> SHIFT; one bit per cycle using an SHW-bit down-counter loaded with shamt; SHIFT -> DONE after the shamt-th step; out_valid asserted shamt+1 cycles after acceptance.
REQ-023 zero = (F==0), neg = F[MSB], evaluated on the final result; all outputs SHALL be stable while in DONE.
REQ-024 DONE with out_ready=0: F, flags and out_valid held indefinitely; no new request accepted.
REQ-025 DONE with out_ready=1 and in_valid=1: result retired and new request accepted in the same cycle (back-to-back, no bubble); with in_valid=0: go to IDLE.
REQ-026 in_ready = 0 throughout SHIFT; in_valid in SHIFT is ignored.

Reset
REQ-027 rst asserted: FSM -> IDLE immediately, F=0, Cout=zero=neg=ovf=0, out_valid=0, counter=0, independent of clk.
REQ-028 rst during SHIFT or DONE aborts the operation; no result SHALL appear after rst deasserts.
REQ-029 First acceptance possible on the first rising clk edge after rst deasserts (in_ready=1 in IDLE).

Verification (WIDTH=32)
REQ-030 sel=1, A=0xFFFFFFFF, B=0xFFFFFFFF, Cin=0, out_ready=1 -> one cycle later F=0xFFFFFFFE, Cout=1, ovf=0, neg=1.
REQ-031 sel=0, A=0x7FFFFFFF, Cin=1 -> F=0x80000000, Cout=0, ovf=1; sel=2, A=3, B=4, Cin=1 -> F=0xFFFFFFFF, Cout=0, zero=0.
REQ-032 sel=0b1100, A=0x12345678, shamt=4, DinL=1 -> out_valid exactly 5 cycles after acceptance, F=0x2345678F, Cout=1; sel=0b1000, shamt=0 -> F=0x12345678 after 1 cycle, Cout=0.
REQ-033 sel=4, A=0x0F0F0F0F, B=0xF0F0F0F0, out_ready=0 for 3 cycles -> F=0, zero=1 held constant, in_ready=0; then out_ready=1 with in_valid=1 -> retire and accept same cycle.
REQ-034 Shift right shamt=31 started, rst pulsed at step 10 -> all outputs 0 immediately, out_valid never asserts for that operation, next op after reset completes correctly.
REQ-035 1000 random ops (random sel, shamt, A, B, fill bits, out_ready stalls) checked against a reference model including latency per REQ-021/022.

Source files
------------

// File: rtl/alu_seq_param.sv
// alu_seq_param: handshaked ALU with single-cycle arithmetic/logic and bit-serial shifts
module alu_seq_param #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             DinL,
    input  logic             DinR,
    input  logic [3:0]       sel,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_next;
    logic [SHW-1:0]   r_cnt;
    logic             r_left, r_fill;
    logic             w_accept, w_arith, w_cout, w_ovf, w_out;
    logic [WIDTH-1:0] w_y, w_log, w_res, w_shf;
    logic [WIDTH:0]   w_sum;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Handshake and next-state; a retiring DONE may accept the next request in the same cycle
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready = 1'b1;
            SHIFT:   w_next = (r_cnt == SHW'(1)) ? DONE : SHIFT;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                w_next    = out_ready ? IDLE : DONE;
            end
            default: w_next = IDLE;
        endcase
        w_accept = in_valid && in_ready;
        if (w_accept) w_next = (sel[3] && shamt != '0) ? SHIFT : DONE;
    end

    // Single-cycle result for arithmetic, logic and zero-distance shifts; one shift step for SHIFT
    always_comb begin
        w_arith = sel[3:2] == 2'b00;
        w_y     = sel[1:0] == 2'b00 ? '0 : sel[1:0] == 2'b01 ? B : sel[1:0] == 2'b10 ? ~B : '1;
        w_sum   = {1'b0, A} + {1'b0, w_y} + {{WIDTH{1'b0}}, Cin};
        w_log   = sel[1:0] == 2'b00 ? A & B : sel[1:0] == 2'b01 ? A | B : sel[1:0] == 2'b10 ? A ^ B : ~A;
        w_res   = sel[3] ? A : sel[2] ? w_log : w_sum[WIDTH-1:0];
        w_cout  = w_arith && w_sum[WIDTH];
        w_ovf   = w_arith && (A[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
        w_shf   = r_left ? {F[WIDTH-2:0], r_fill} : {r_fill, F[WIDTH-1:1]};
        w_out   = r_left ? F[WIDTH-1] : F[0];
    end

    // Result/flag registers: load on acceptance, then shift one bit per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F      <= '0;
            Cout   <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            r_cnt  <= '0;
            r_left <= 1'b0;
            r_fill <= 1'b0;
        end else if (w_accept) begin
            F      <= w_res;
            Cout   <= w_cout;
            zero   <= w_res == '0;
            neg    <= w_res[WIDTH-1];
            ovf    <= w_ovf;
            r_cnt  <= shamt;
            r_left <= sel[2];
            r_fill <= sel[2] ? DinL : DinR;
        end else if (r_state == SHIFT) begin
            F      <= w_shf;
            Cout   <= w_out;
            zero   <= w_shf == '0;
            neg    <= w_shf[WIDTH-1];
            r_cnt  <= r_cnt - SHW'(1);
        end
    end
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: vector table, corner sequences and randomized model check for alu_seq_param
module tb_alu_seq_param;
    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a, b;
        logic        cin, dl, dr;
        logic [4:0]  sh;
        logic [31:0] f;
        logic        cout, z, n, o;
        int          lat;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, Cin = 1'b0, DinL = 1'b0, DinR = 1'b0;
    logic [31:0] A = '0, B = '0, F;
    logic [3:0]  sel = '0;
    logic [4:0]  shamt = '0;
    logic        Cout, zero, neg, ovf, out_valid;
    int          n_cmp = 0, n_err = 0;
    vec_t        tbl[14];

    alu_seq_param #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .DinL(DinL), .DinR(DinR), .sel(sel), .shamt(shamt),
        .F(F), .Cout(Cout), .zero(zero), .neg(neg), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: arithmetic via signed/unsigned integer sums, shifts via whole-word shift operators
    function automatic vec_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic dl, input logic dr, input logic [4:0] sh);
        vec_t r;
        logic [31:0] y, m;
        longint unsigned us;
        longint ss;
        r = '{s, a, b, c, dl, dr, sh, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        case (s[3:2])
            2'b00: begin
                y = s[1:0] == 0 ? 32'h0 : s[1:0] == 1 ? b : s[1:0] == 2 ? ~b : 32'hFFFF_FFFF;
                us = longint'(a) + longint'(y) + longint'(c);
                ss = longint'($signed(a)) + longint'($signed(y)) + longint'(c);
                r.f = us[31:0];
                r.cout = us[32];
                r.o = ss > 64'sd2147483647 || ss < -64'sd2147483648;
            end
            2'b01: r.f = s[1:0] == 0 ? a & b : s[1:0] == 1 ? a | b : s[1:0] == 2 ? a ^ b : ~a;
            2'b10: begin
                m = 32'hFFFF_FFFF >> sh;
                r.f = (a >> sh) | (dr ? ~m : 32'h0);
                r.cout = sh != 0 && a[sh - 5'd1];
                r.lat = int'(sh) + 1;
            end
            default: begin
                us = (64'd1 << sh) - 64'd1;
                r.f = (a << sh) | (dl ? us[31:0] : 32'h0);
                r.cout = sh != 0 && a[6'd32 - {1'b0, sh}];
                r.lat = int'(sh) + 1;
            end
        endcase
        r.z = r.f == 0;
        r.n = r.f[31];
        return r;
    endfunction

    task automatic drive(input vec_t v);
        sel = v.sel; A = v.a; B = v.b; Cin = v.cin; DinL = v.dl; DinR = v.dr; shamt = v.sh;
    endtask

    task automatic scramble();
        sel = 4'($urandom); A = $urandom; B = $urandom; shamt = 5'($urandom);
        Cin = 1'($urandom); DinL = 1'($urandom); DinR = 1'($urandom);
    endtask

    // Issue one op, measure latency, check result, hold through a stall, then retire it
    task automatic do_op(input string tag, input vec_t v, input int stall);
        int lat, g;
        logic [31:0] held;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        out_ready = 1'b0;
        g = 0;
        while (!in_ready && g < 50) begin @(negedge clk); g++; end
        chk({tag, ".accept"}, in_ready, 1'b1);
        @(posedge clk); #1;
        scramble();
        in_valid = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        chk({tag, ".lat"}, lat, v.lat);
        chk({tag, ".F"}, F, v.f);
        chk({tag, ".flags"}, {Cout, zero, neg, ovf}, {v.cout, v.z, v.n, v.o});
        held = F;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold"}, {out_valid, in_ready, F}, {1'b1, 1'b0, held});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t v, w;
        bit seen;
        tbl[0]  = '{4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0,  32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[1]  = '{4'h0, 32'h7FFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 5'd0,  32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[2]  = '{4'h2, 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[3]  = '{4'hC, 32'h1234_5678, 32'h0,         1'b0, 1'b1, 1'b0, 5'd4,  32'h2345_678F, 1'b1, 1'b0, 1'b0, 1'b0, 5};
        tbl[4]  = '{4'h8, 32'h1234_5678, 32'h0,         1'b0, 1'b1, 1'b1, 5'd0,  32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[5]  = '{4'h4, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[6]  = '{4'h3, 32'h0000_0005, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[7]  = '{4'h7, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[8]  = '{4'h9, 32'h8000_0001, 32'h0,         1'b0, 1'b1, 1'b0, 5'd1,  32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[9]  = '{4'hB, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 32};
        tbl[10] = '{4'h5, 32'h0000_1234, 32'h8765_0000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h8765_1234, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[11] = '{4'h6, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{4'h1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1};
        tbl[13] = '{4'hF, 32'h0000_0001, 32'h0,         1'b0, 1'b0, 1'b1, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32};
        #1;
        chk("reset.outs", {F, Cout, zero, neg, ovf, out_valid}, 38'h0);
        chk("reset.in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) do_op($sformatf("vec%0d", i), tbl[i], i % 3);

        // Stall in DONE, then retire and accept the next request on the same edge
        do_op("stall", tbl[5], 3);
        @(negedge clk);
        drive(tbl[5]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b2b.hold", {out_valid, in_ready, zero, F}, {1'b1, 1'b0, 1'b1, 32'h0});
        end
        @(negedge clk);
        drive(tbl[0]);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 chk("b2b.in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b.result", {out_valid, Cout, F}, {1'b1, 1'b1, 32'hFFFF_FFFE});
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;

        // Reset in the middle of a long right shift
        @(negedge clk);
        v = model(4'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b1, 5'd31);
        drive(v);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("abort.outs", {F, Cout, zero, neg, ovf, out_valid}, 38'h0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1 seen |= out_valid; end
        chk("abort.no_result", seen, 1'b0);
        out_ready = 1'b0;
        do_op("after_abort", tbl[3], 0);

        // Randomized ops against the reference model
        for (int i = 0; i < 1000; i++) begin
            w = model(4'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4)));
            do_op($sformatf("rnd%0d", i), w, $urandom_range(0, 2));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
